// File: rtl/fetch_seq_ctrl_if.sv
// Fetch sequencer bundle: decode hold/redirect inputs, imem request/response, decoded instruction out.
// Signal prefixes are from the sequencer's point of view (master modport).
interface fetch_seq_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              i_stall;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_addr;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_valid;
  logic [INST_W-1:0] i_imem_inst;
  logic [INST_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_addr;
  logic              o_inst_valid;
  logic              o_err;

  modport master (
    input  i_stall, i_redirect, i_redirect_addr, i_imem_valid, i_imem_inst,
    output o_imem_req, o_imem_addr, o_inst, o_inst_addr, o_inst_valid, o_err
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_addr, i_imem_valid, i_imem_inst,
    input  o_imem_req, o_imem_addr, o_inst, o_inst_addr, o_inst_valid, o_err
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: one outstanding imem request, redirect/kill of in-flight fetches, decode hold.
// Define FETCH_PERF_EN to add saturating fetched/stall/flush counters.
module fetch_seq_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int INST_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int PC_STEP = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  fetch_seq_ctrl_if.master        bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             o_perf_fetched,
  output logic [31:0]             o_perf_stall,
  output logic [31:0]             o_perf_flush
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_redir;
  logic              r_kill;
  logic [7:0]        r_wait_cnt;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_addr;
  logic              r_inst_valid;
  logic              r_err;
  logic              w_timeout;

  assign w_timeout = (r_wait_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_redir      <= '0;
      r_kill       <= 1'b0;
      r_wait_cnt   <= '0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
      r_inst_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_redirect) r_pc <= bus.i_redirect_addr;
          r_state <= S_REQ;
        end
        S_REQ: begin
          r_wait_cnt <= '0;
          if (bus.i_redirect) begin
            r_kill  <= 1'b1;
            r_redir <= bus.i_redirect_addr;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_imem_valid) begin
            if (bus.i_redirect) begin
              r_pc    <= bus.i_redirect_addr;
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else if (r_kill) begin
              r_pc    <= r_redir;
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst       <= bus.i_imem_inst;
              r_inst_addr  <= r_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= r_pc + STEP;
              r_state      <= S_HOLD;
            end
          end else if (w_timeout) begin
            // Retry the fetch; a redirect seen this cycle or earlier picks the retry address.
            r_err   <= 1'b1;
            r_kill  <= 1'b0;
            if (bus.i_redirect) r_pc <= bus.i_redirect_addr;
            else if (r_kill)    r_pc <= r_redir;
            r_state <= S_REQ;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (bus.i_redirect) begin
              r_kill  <= 1'b1;
              r_redir <= bus.i_redirect_addr;
            end
          end
        end
        S_HOLD: begin
          if (bus.i_redirect) begin
            r_inst_valid <= 1'b0;
            r_pc         <= bus.i_redirect_addr;
            r_state      <= S_REQ;
          end else if (!bus.i_stall) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_imem_req   = (r_state == S_REQ);
  assign bus.o_imem_addr  = r_pc;
  assign bus.o_inst       = r_inst;
  assign bus.o_inst_addr  = r_inst_addr;
  assign bus.o_inst_valid = r_inst_valid;
  assign bus.o_err        = r_err;

`ifdef FETCH_PERF_EN
  logic        w_consume;
  logic        w_stall_cyc;
  logic        w_flush;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  assign w_consume   = (r_state == S_HOLD) && !bus.i_redirect && !bus.i_stall;
  assign w_stall_cyc = (r_state == S_HOLD) && bus.i_stall;
  assign w_flush     = ((r_state == S_WAIT) && bus.i_imem_valid && (bus.i_redirect || r_kill)) ||
                       ((r_state == S_HOLD) && bus.i_redirect);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_flush   <= '0;
    end else begin
      if (w_consume   && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stall_cyc && (r_perf_stall   != '1)) r_perf_stall   <= r_perf_stall + 32'd1;
      if (w_flush     && (r_perf_flush   != '1)) r_perf_flush   <= r_perf_flush + 32'd1;
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_stall   = r_perf_stall;
  assign o_perf_flush   = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_seq_ctrl;
  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int TIMEOUT = 16;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  fetch_seq_ctrl_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_seq_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .TIMEOUT(TIMEOUT), .PC_STEP(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched (perf_fetched),
    .o_perf_stall   (perf_stall),
    .o_perf_flush   (perf_flush)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Memory responder: valid arrives mem_lat cycles after the first WAIT cycle, once per request.
  int          mem_lat  = 2;
  bit          mem_mute = 1'b0;
  bit          mem_rand = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = '0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    logic        req_seen;
    logic [63:0] req_a;
    req_seen = bus.o_imem_req;
    req_a    = bus.o_imem_addr;
    @(posedge i_clk);
    #1;
    bus.i_imem_valid = 1'b0;
    if (req_seen && !mem_mute) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_rand ? int'($urandom_range(0, 5)) : mem_lat;
      mem_addr = req_a;
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        bus.i_imem_valid = 1'b1;
        bus.i_imem_inst  = mem_data(mem_addr);
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_addr = '0;
    bus.i_imem_valid = 1'b0;
    bus.i_imem_inst = '0;
    mem_pend = 1'b0;
    mem_mute = 1'b0;
    mem_rand = 1'b0;
    mem_lat  = 2;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic wait_inst(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (bus.o_inst_valid === 1'b1) begin ok = 1'b1; break; end
      if (i < max) tick();
    end
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (bus.o_imem_req === 1'b1) begin ok = 1'b1; break; end
      if (i < max) tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    i_rst_n = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_addr = '0;
    bus.i_imem_valid = 1'b0;
    bus.i_imem_inst = '0;
    @(posedge i_clk);
    #1;
    total++; if (bus.o_imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", bus.o_imem_req); end
    total++; if (bus.o_inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.o_inst_valid); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", bus.o_err); end
    total++; if (bus.o_imem_addr !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", bus.o_imem_addr); end
    total++; if (bus.o_inst !== 32'h0 || bus.o_inst_addr !== 64'h0) begin bad++; $display("FAIL rst_inst got=%h/%h want=0/0", bus.o_inst, bus.o_inst_addr); end
    i_rst_n = 1'b1;
    total++; if (bus.o_imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%0b want=0", bus.o_imem_req); end
    tick();
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h0) begin bad++; $display("FAIL first_req got=%0b@%h want=1@0", bus.o_imem_req, bus.o_imem_addr); end
    bus.i_stall = 1'b1;
    wait_inst(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_inst_timeout got=none want=valid"); end
    #3;
    i_rst_n = 1'b0;
    #1;
    total++; if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 32'h0 || bus.o_inst_addr !== 64'h0)
      begin bad++; $display("FAIL async_rst got=%0b/%h/%h want=0/0/0", bus.o_inst_valid, bus.o_inst, bus.o_inst_addr); end
  endtask

  task automatic test_sequential();
    int          n_req;
    int          n_val;
    logic [63:0] raddr [4];
    logic [63:0] vaddr [4];
    logic [31:0] vinst [4];
    int          vcyc  [4];
    do_reset();
    n_req = 0;
    n_val = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.o_imem_req === 1'b1) begin
        if (n_req < 4) raddr[n_req] = bus.o_imem_addr;
        n_req++;
      end
      if (bus.o_inst_valid === 1'b1) begin
        if (n_val < 4) begin
          vaddr[n_val] = bus.o_inst_addr;
          vinst[n_val] = bus.o_inst;
          vcyc[n_val]  = c;
        end
        n_val++;
      end
      tick();
    end
    total++; if (n_req != 3) begin bad++; $display("FAIL seq_nreq got=%0d want=3", n_req); end
    total++; if (n_val != 3) begin bad++; $display("FAIL seq_nvalid got=%0d want=3", n_val); end
    if (n_req >= 3 && n_val >= 3) begin
      for (int k = 0; k < 3; k++) begin
        total++; if (raddr[k] !== 64'(4 * k)) begin bad++; $display("FAIL seq_req_addr%0d got=%h want=%h", k, raddr[k], 64'(4 * k)); end
        total++; if (vaddr[k] !== 64'(4 * k) || vinst[k] !== mem_data(64'(4 * k)))
          begin bad++; $display("FAIL seq_inst%0d got=%h@%h want=%h@%h", k, vinst[k], vaddr[k], mem_data(64'(4 * k)), 64'(4 * k)); end
      end
      total++; if (vcyc[1] - vcyc[0] != 5 || vcyc[2] - vcyc[1] != 5)
        begin bad++; $display("FAIL seq_period got=%0d,%0d want=5,5", vcyc[1] - vcyc[0], vcyc[2] - vcyc[1]); end
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] saved;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.o_inst_valid === 1'b1 && bus.o_inst_addr === 64'h4) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL stall_reach got=none want=inst@4"); end
    saved = bus.o_inst;
    for (int k = 0; k < 5; k++) begin
      bus.i_stall = 1'b1;
      total++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== saved || bus.o_inst_addr !== 64'h4)
        begin bad++; $display("FAIL stall_hold%0d got=%0b %h@%h want=1 %h@4", k, bus.o_inst_valid, bus.o_inst, bus.o_inst_addr, saved); end
      total++; if (bus.o_imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq%0d got=%0b want=0", k, bus.o_imem_req); end
      tick();
      bus.i_imem_valid = 1'b1;
      bus.i_imem_inst  = 32'hDEAD_BEEF;
    end
    bus.i_stall = 1'b0;
    total++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== saved)
      begin bad++; $display("FAIL stall_stray got=%0b %h want=1 %h", bus.o_inst_valid, bus.o_inst, saved); end
    tick();
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h8 || bus.o_inst_valid !== 1'b0)
      begin bad++; $display("FAIL stall_next got=%0b@%h v=%0b want=1@8 v=0", bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit seen_valid;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_imem_req === 1'b1 && bus.o_imem_addr === 64'h8) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (!ok) begin bad++; $display("FAIL rw_reach got=none want=req@8"); end
    mem_lat = 3;
    tick();
    bus.i_redirect = 1'b1;
    bus.i_redirect_addr = 64'h100;
    tick();
    bus.i_redirect = 1'b0;
    seen_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_inst_valid === 1'b1) seen_valid = 1'b1;
      if (bus.o_imem_req === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    mem_lat = 2;
    total++; if (!ok) begin bad++; $display("FAIL rw_req_timeout got=none want=req"); end
    total++; if (seen_valid) begin bad++; $display("FAIL rw_discard got=valid want=none"); end
    total++; if (bus.o_imem_addr !== 64'h100) begin bad++; $display("FAIL rw_addr got=%h want=100", bus.o_imem_addr); end
    wait_inst(20, ok);
    total++; if (!ok || bus.o_inst_addr !== 64'h100 || bus.o_inst !== mem_data(64'h100))
      begin bad++; $display("FAIL rw_inst got=%h@%h want=%h@100", bus.o_inst, bus.o_inst_addr, mem_data(64'h100)); end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset();
    wait_inst(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rh_reach got=none want=valid"); end
    bus.i_stall = 1'b1;
    bus.i_redirect = 1'b1;
    bus.i_redirect_addr = 64'h200;
    tick();
    bus.i_redirect = 1'b0;
    total++; if (bus.o_inst_valid !== 1'b0) begin bad++; $display("FAIL rh_drop got=%0b want=0", bus.o_inst_valid); end
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h200)
      begin bad++; $display("FAIL rh_req got=%0b@%h want=1@200", bus.o_imem_req, bus.o_imem_addr); end
    wait_inst(20, ok);
    total++; if (!ok || bus.o_inst_addr !== 64'h200) begin bad++; $display("FAIL rh_prefill got=%h want=200", bus.o_inst_addr); end
    bus.i_stall = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    mem_mute = 1'b1;
    tick();
    repeat (16) tick();
    total++; if (bus.o_err !== 1'b0 || bus.o_imem_req !== 1'b0)
      begin bad++; $display("FAIL to_early got=err%0b req%0b want=err0 req0", bus.o_err, bus.o_imem_req); end
    tick();
    total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0b want=1", bus.o_err); end
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h0)
      begin bad++; $display("FAIL to_retry got=%0b@%h want=1@0", bus.o_imem_req, bus.o_imem_addr); end
    mem_mute = 1'b0;
    wait_inst(20, ok);
    total++; if (!ok || bus.o_inst_addr !== 64'h0) begin bad++; $display("FAIL to_recover got=%h want=0", bus.o_inst_addr); end
    total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b want=1", bus.o_err); end
    tick();
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h4)
      begin bad++; $display("FAIL to_next got=%0b@%h want=1@4", bus.o_imem_req, bus.o_imem_addr); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    bus.i_redirect = 1'b1;
    bus.i_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.i_redirect = 1'b0;
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin bad++; $display("FAIL wrap_req got=%0b@%h want=1@fffffffffffffffc", bus.o_imem_req, bus.o_imem_addr); end
    wait_inst(20, ok);
    total++; if (!ok || bus.o_inst !== mem_data(64'hFFFF_FFFF_FFFF_FFFC))
      begin bad++; $display("FAIL wrap_inst got=%h want=%h", bus.o_inst, mem_data(64'hFFFF_FFFF_FFFF_FFFC)); end
    tick();
    total++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 64'h0)
      begin bad++; $display("FAIL wrap_next got=%0b@%h want=1@0", bus.o_imem_req, bus.o_imem_addr); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_inst(20, ok);
      tick();
    end
    tick();
    bus.i_redirect = 1'b1;
    bus.i_redirect_addr = 64'h40;
    tick();
    bus.i_redirect = 1'b0;
    wait_req(20, ok);
    total++; if (!ok || bus.o_imem_addr !== 64'h40) begin bad++; $display("FAIL perf_req got=%h want=40", bus.o_imem_addr); end
    total++; if (perf_fetched !== 32'd3) begin bad++; $display("FAIL perf_fetched got=%0d want=3", perf_fetched); end
    total++; if (perf_flush !== 32'd1) begin bad++; $display("FAIL perf_flush got=%0d want=1", perf_flush); end
    total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL perf_stall got=%0d want=0", perf_stall); end
  endtask
`endif

  // Model works on fetch transactions: each request window either delivers its instruction
  // or is cancelled by any redirect seen from the request cycle through the response cycle.
  task automatic test_random();
    bit          exp_req;
    bit          pres;
    bit          first;
    bit          win_redir;
    bit          stall;
    bit          redir;
    bit          resp;
    bit          nreq;
    logic [63:0] pres_addr;
    logic [31:0] pres_inst;
    logic [63:0] next_addr;
    logic [63:0] cur_addr;
    logic [63:0] raddr;
    do_reset();
    mem_rand  = 1'b1;
    exp_req   = 1'b0;
    pres      = 1'b0;
    first     = 1'b1;
    win_redir = 1'b0;
    pres_addr = '0;
    pres_inst = '0;
    next_addr = '0;
    cur_addr  = '0;
    for (int c = 0; c < 1500; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redir = ($urandom_range(0, 15) == 0);
      raddr = {$urandom(), $urandom()};
      raddr[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) raddr[63:8] = '1;
      bus.i_stall = stall;
      bus.i_redirect = redir;
      bus.i_redirect_addr = raddr;
      total++; if (bus.o_imem_req !== exp_req) begin bad++; $display("FAIL rnd_req c%0d got=%0b want=%0b", c, bus.o_imem_req, exp_req); end
      total++; if (bus.o_inst_valid !== pres) begin bad++; $display("FAIL rnd_valid c%0d got=%0b want=%0b", c, bus.o_inst_valid, pres); end
      if (pres) begin
        total++; if (bus.o_inst_addr !== pres_addr || bus.o_inst !== pres_inst)
          begin bad++; $display("FAIL rnd_inst c%0d got=%h@%h want=%h@%h", c, bus.o_inst, bus.o_inst_addr, pres_inst, pres_addr); end
      end
      if (exp_req) begin
        total++; if (bus.o_imem_addr !== next_addr) begin bad++; $display("FAIL rnd_addr c%0d got=%h want=%h", c, bus.o_imem_addr, next_addr); end
        cur_addr  = next_addr;
        win_redir = 1'b0;
      end
      resp = bus.i_imem_valid;
      if (redir) begin
        win_redir = 1'b1;
        next_addr = raddr;
      end
      nreq = first || (pres && (!stall || redir)) || (resp && win_redir);
      if (resp && !win_redir) begin
        pres      = 1'b1;
        pres_addr = cur_addr;
        pres_inst = mem_data(cur_addr);
        next_addr = cur_addr + 64'd4;
      end else if (!(pres && stall && !redir)) begin
        pres = 1'b0;
      end
      exp_req = nreq;
      first   = 1'b0;
      tick();
    end
    bus.i_redirect = 1'b0;
    bus.i_stall = 1'b0;
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%0b want=0", bus.o_err); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_timeout();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
